// File: rtl/issue_ctrl.sv
// Instruction queue between fetcher and decode: circular FIFO of instr/pc pairs,
// issues the head in order once the ROB and its target unit (RS/LSB) can take it.
module issue_ctrl #(
    parameter int IQ_DEPTH_LOG = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 in_fetch_valid,
    input  logic [31:0]          in_fetch_instr,
    input  logic [31:0]          in_fetch_pc,
    output logic                 out_fetch_ready,
    input  logic                 in_rob_full,
    input  logic                 in_rs_full,
    input  logic                 in_lsb_full,
    input  logic                 in_flush,
    output logic                 out_issue_valid,
    output logic [31:0]          out_issue_instr,
    output logic [31:0]          out_issue_pc,
    output logic [1:0]           out_issue_unit,
    output logic [CNT_WIDTH-1:0] out_stall_cnt
);

    localparam int DEPTH = 1 << IQ_DEPTH_LOG;

    typedef enum logic [1:0] {
        UNIT_ROB = 2'd0,
        UNIT_RS  = 2'd1,
        UNIT_LSB = 2'd2
    } unit_e;

    logic [31:0]             instr_q [DEPTH];
    logic [31:0]             pc_q    [DEPTH];
    logic [IQ_DEPTH_LOG-1:0] head, tail;
    logic [IQ_DEPTH_LOG:0]   count;

    logic [31:0] head_instr;
    unit_e       head_unit;
    logic        head_legal;
    logic        full, not_empty, active, blocked;
    logic        push, pop, issue, stall;

    assign head_instr = instr_q[head];

    always_comb begin
        head_unit  = UNIT_ROB;
        head_legal = 1'b1;
        case (head_instr[6:0])
            7'b0110111, 7'b0010111, 7'b1101111:             head_unit = UNIT_ROB;
            7'b0000011, 7'b0100011:                         head_unit = UNIT_LSB;
            7'b1100111, 7'b1100011, 7'b0010011, 7'b0110011: head_unit = UNIT_RS;
            default:                                        head_legal = 1'b0;
        endcase
    end

    // count never exceeds DEPTH, so its MSB alone marks a full queue
    assign full      = count[IQ_DEPTH_LOG];
    assign not_empty = (count != '0);
    assign active    = rdy && !in_flush;
    assign blocked   = in_rob_full
                    || ((head_unit == UNIT_RS)  && in_rs_full)
                    || ((head_unit == UNIT_LSB) && in_lsb_full);

    // Illegal heads are discarded without waiting on any structure
    assign issue = active && not_empty && head_legal && !blocked;
    assign stall = active && not_empty && head_legal && blocked;
    assign pop   = active && not_empty && (!head_legal || !blocked);
    assign push  = active && in_fetch_valid && !full;

    assign out_fetch_ready = !full && !rst;

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[tail] <= in_fetch_instr;
            pc_q[tail]    <= in_fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy && in_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + IQ_DEPTH_LOG'(1);
            if (pop)  head <= head + IQ_DEPTH_LOG'(1);
            case ({push, pop})
                2'b10:   count <= count + (IQ_DEPTH_LOG+1)'(1);
                2'b01:   count <= count - (IQ_DEPTH_LOG+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_issue_valid <= 1'b0;
            out_issue_instr <= '0;
            out_issue_pc    <= '0;
            out_issue_unit  <= '0;
        end else if (!rdy) begin
            out_issue_valid <= 1'b0;
        end else if (issue) begin
            out_issue_valid <= 1'b1;
            out_issue_instr <= head_instr;
            out_issue_pc    <= pc_q[head];
            out_issue_unit  <= head_unit;
        end else begin
            out_issue_valid <= 1'b0;
            out_issue_instr <= '0;
            out_issue_pc    <= '0;
            out_issue_unit  <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_stall_cnt <= '0;
        end else if (stall && (out_stall_cnt != '1)) begin
            out_stall_cnt <= out_stall_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Randomized bench for issue_ctrl against a queue-based reference model;
// a narrow stall counter is used so saturation is reached.
module tb_issue_ctrl;

    localparam int CW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst, rdy, in_fetch_valid, in_rob_full, in_rs_full, in_lsb_full, in_flush;
    logic [31:0]   in_fetch_instr, in_fetch_pc;
    logic          out_fetch_ready, out_issue_valid;
    logic [31:0]   out_issue_instr, out_issue_pc;
    logic [1:0]    out_issue_unit;
    logic [CW-1:0] out_stall_cnt;

    issue_ctrl #(.IQ_DEPTH_LOG(2), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_fetch_valid(in_fetch_valid), .in_fetch_instr(in_fetch_instr), .in_fetch_pc(in_fetch_pc),
        .out_fetch_ready(out_fetch_ready),
        .in_rob_full(in_rob_full), .in_rs_full(in_rs_full), .in_lsb_full(in_lsb_full),
        .in_flush(in_flush),
        .out_issue_valid(out_issue_valid), .out_issue_instr(out_issue_instr),
        .out_issue_pc(out_issue_pc), .out_issue_unit(out_issue_unit),
        .out_stall_cnt(out_stall_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model state
    logic [63:0] mq[$];          // {pc, instr}, front = oldest
    logic        m_valid;
    logic [31:0] m_instr, m_pc;
    logic [1:0]  m_unit;
    int          m_stall;
    bit          m_known;        // issue data fields defined (not after a flush)

    function automatic int unit_of(input logic [31:0] ins);
        logic [6:0] op = ins[6:0];
        if (op == 7'h37 || op == 7'h17 || op == 7'h6F) return 0;
        if (op == 7'h03 || op == 7'h23) return 2;
        if (op == 7'h67 || op == 7'h63 || op == 7'h13 || op == 7'h33) return 1;
        return -1;
    endfunction

    task automatic model_edge();
        if (rst) begin
            mq.delete();
            m_valid = 0; m_instr = 0; m_pc = 0; m_unit = 0; m_stall = 0; m_known = 1;
        end else if (!rdy) begin
            m_valid = 0;
        end else if (in_flush) begin
            mq.delete();
            m_valid = 0; m_known = 0;
        end else begin
            bit can_push = (mq.size() < DEPTH);
            bit issued = 0;
            if (mq.size() > 0) begin
                int u = unit_of(mq[0][31:0]);
                if (u < 0) begin
                    void'(mq.pop_front());
                end else if (in_rob_full || (u == 1 && in_rs_full) || (u == 2 && in_lsb_full)) begin
                    if (m_stall < (1 << CW) - 1) m_stall++;
                end else begin
                    logic [63:0] e = mq.pop_front();
                    issued = 1;
                    m_instr = e[31:0]; m_pc = e[63:32]; m_unit = 2'(u);
                end
            end
            m_valid = issued;
            if (!issued) begin
                m_instr = 0; m_pc = 0; m_unit = 0;
            end
            m_known = 1;
            if (in_fetch_valid && can_push) mq.push_back({in_fetch_pc, in_fetch_instr});
        end
    endtask

    task automatic step(input bit r, input bit rd, input bit fv, input logic [31:0] ins,
                        input logic [31:0] pc, input bit robf, input bit rsf, input bit lsbf,
                        input bit fl);
        @(negedge clk);
        rst = r; rdy = rd; in_fetch_valid = fv; in_fetch_instr = ins; in_fetch_pc = pc;
        in_rob_full = robf; in_rs_full = rsf; in_lsb_full = lsbf; in_flush = fl;
        #1;
        check("fetch_ready", 64'(out_fetch_ready), 64'(!r && mq.size() < DEPTH));
        @(posedge clk);
        model_edge();
        #1;
        check("issue_valid", 64'(out_issue_valid), 64'(m_valid));
        if (m_known) begin
            check("issue_instr", 64'(out_issue_instr), 64'(m_instr));
            check("issue_pc",    64'(out_issue_pc),    64'(m_pc));
            check("issue_unit",  64'(out_issue_unit),  64'(m_unit));
        end
        check("stall_cnt", 64'(out_stall_cnt), 64'(m_stall));
    endtask

    // Normal cycle helpers
    task automatic idle(input bit robf, input bit rsf, input bit lsbf);
        step(0, 1, 0, 0, 0, robf, rsf, lsbf, 0);
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] pc, input bit robf);
        step(0, 1, 1, ins, pc, robf, 0, 0, 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h03, 7'h23, 7'h67,
                                 7'h63, 7'h13, 7'h33, 7'h7F, 7'h00, 7'h0B};
        logic [31:0] r = $urandom;
        r[6:0] = ops[$urandom_range(0, 11)];
        return r;
    endfunction

    initial begin
        mq.delete(); m_valid = 0; m_instr = 0; m_pc = 0; m_unit = 0; m_stall = 0; m_known = 1;
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h00500093, 0, 0, 0, 0, 1);

        // ADDI issue latency
        push(32'h00500093, 32'h0, 0);
        idle(0, 0, 0);
        idle(0, 0, 0);

        // Fill under ROB-full, 5th push refused, then drain in order
        for (int i = 0; i < 5; i++) push(32'h00000013 | (i << 7), 32'h100 + i * 4, 1);
        idle(1, 0, 0);
        for (int i = 0; i < 5; i++) idle(0, 0, 0);

        // LW blocked by LSB only
        push(32'h0000a103, 32'h200, 0);
        idle(0, 0, 1);
        idle(0, 0, 1);
        idle(0, 0, 0);
        idle(0, 0, 0);

        // Flush with three queued and a simultaneous push
        push(32'h00100093, 32'h300, 1);
        push(32'h00200093, 32'h304, 1);
        push(32'h00300093, 32'h308, 1);
        step(0, 1, 1, 32'h00400093, 32'h30C, 1, 0, 0, 1);
        idle(0, 0, 0);
        idle(0, 0, 0);

        // Illegal head discarded, LUI follows
        push(32'h0000007F, 32'h400, 1);
        push(32'h123450b7, 32'h404, 1);
        idle(0, 0, 0);
        idle(0, 0, 0);
        idle(0, 0, 0);

        // Freeze mid-stream, then resume; reset mid-stream
        push(32'h00000033, 32'h500, 1);
        push(32'h00000063, 32'h504, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h00000013, 32'h600, 0, 0, 0, 0);
        idle(0, 0, 0);
        push(32'h00000023, 32'h508, 0);
        step(1, 1, 1, 32'h00000013, 32'h50C, 0, 0, 0, 0);
        idle(0, 0, 0);

        // Saturate the narrow stall counter
        push(32'h00000013, 32'h700, 1);
        for (int i = 0; i < 20; i++) idle(1, 0, 0);
        idle(0, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) < 6, rand_instr(), $urandom,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
